tub_scan_ctrl: RTL and testbench



---
 rtl/tub_scan_ctrl.sv | 120 ++++++++++++
 tb/tb_tub_scan_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/tub_scan_ctrl.sv
// Captures two 3-bit operands, forms |a-b| with a sign flag and scans them onto a
// sign tube and a magnitude tube over one shared segment bus. Define TUB_ACTIVE_LOW_EN for common-anode polarity.
module tub_scan_ctrl #(
  parameter int CLK_DIV   = 100000,
  parameter int BLANK_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic [1:0] tub_sel,
  output logic [7:0] tub_control
);
  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CALC, SHOW} state_t;

  state_t        state, nxt_state;
  logic [2:0]    a_q, b_q, mag_q, nxt_mag;
  logic          neg_q, nxt_neg;
  logic [DW-1:0] div_cnt, nxt_div;
  logic          digit, nxt_digit;
  logic          busy_q, done_q;
  logic [1:0]    sel_q, nxt_sel;
  logic [7:0]    seg_q, nxt_seg;

  function automatic logic [7:0] glyph(input logic [2:0] v);
    case (v)
      3'd0: glyph = 8'hFC;
      3'd1: glyph = 8'h60;
      3'd2: glyph = 8'hDA;
      3'd3: glyph = 8'hF2;
      3'd4: glyph = 8'h66;
      3'd5: glyph = 8'hB6;
      3'd6: glyph = 8'hBE;
      default: glyph = 8'hE0;
    endcase
  endfunction

  // Next-state is computed here so the drive outputs can be registered
  // from it and land in the same cycle as the state they describe.
  always_comb begin
    nxt_state = state;
    nxt_div   = div_cnt;
    nxt_digit = digit;
    nxt_neg   = neg_q;
    nxt_mag   = mag_q;
    case (state)
      IDLE: if (load) nxt_state = CALC;
      CALC: begin
        nxt_state = SHOW;
        nxt_div   = '0;
        nxt_digit = 1'b1;
        nxt_neg   = (a_q < b_q);
        nxt_mag   = (a_q < b_q) ? (b_q - a_q) : (a_q - b_q);
      end
      SHOW: begin
        if (load) begin
          nxt_state = CALC;
        end else if (div_cnt == DW'(CLK_DIV - 1)) begin
          nxt_div   = '0;
          nxt_digit = ~digit;
        end else begin
          nxt_div = div_cnt + DW'(1);
        end
      end
      default: nxt_state = IDLE;
    endcase

    nxt_sel = 2'b00;
    nxt_seg = 8'h00;
    if (nxt_state == SHOW && int'(nxt_div) >= BLANK_CYC) begin
      nxt_sel = nxt_digit ? 2'b10 : 2'b01;
      nxt_seg = nxt_digit ? (nxt_neg ? 8'h02 : 8'h00) : glyph(nxt_mag);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      mag_q   <= '0;
      div_cnt <= '0;
      digit   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sel_q   <= 2'b00;
      seg_q   <= 8'h00;
    end else begin
      state   <= nxt_state;
      div_cnt <= nxt_div;
      digit   <= nxt_digit;
      neg_q   <= nxt_neg;
      mag_q   <= nxt_mag;
      if (load && state != CALC) begin
        a_q <= a;
        b_q <= b;
      end
      busy_q <= (nxt_state == CALC);
      done_q <= (state == CALC);
      sel_q  <= nxt_sel;
      seg_q  <= nxt_seg;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
`ifdef TUB_ACTIVE_LOW_EN
  assign tub_sel     = ~sel_q;
  assign tub_control = ~seg_q;
`else
  assign tub_sel     = sel_q;
  assign tub_control = seg_q;
`endif
endmodule

// File: tb/tb_tub_scan_ctrl.sv
// Bench for tub_scan_ctrl: a show-time model (elapsed cycles since SHOW entry)
// checked every cycle, plus literal expectations at key points of each scenario.
module tb_tub_scan_ctrl;
  localparam int CLK_DIV   = 4;
  localparam int BLANK_CYC = 1;

  logic       clk = 1'b0;
  logic       rst, load;
  logic [2:0] a, b;
  logic       busy, done;
  logic [1:0] tub_sel;
  logic [7:0] tub_control;

  int vectors = 0;
  int miscompares = 0;

  tub_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .load(load),
    .busy(busy), .done(done), .tub_sel(tub_sel), .tub_control(tub_control)
  );

  always #5 clk = ~clk;

`ifdef TUB_ACTIVE_LOW_EN
  localparam logic [1:0] SEL_INV = 2'b11;
  localparam logic [7:0] SEG_INV = 8'hFF;
`else
  localparam logic [1:0] SEL_INV = 2'b00;
  localparam logic [7:0] SEG_INV = 8'h00;
`endif

  logic [7:0] glyph_t [8];
  initial begin
    glyph_t[0] = 8'hFC; glyph_t[1] = 8'h60; glyph_t[2] = 8'hDA; glyph_t[3] = 8'hF2;
    glyph_t[4] = 8'h66; glyph_t[5] = 8'hB6; glyph_t[6] = 8'hBE; glyph_t[7] = 8'hE0;
  end

  // Model: mode 0=idle, 1=calc, 2=show; m_t counts cycles since entering show.
  int m_mode = 0, m_a = 0, m_b = 0, m_t = 0;
  bit armed = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0;
      armed  = 1;
    end else begin
      case (m_mode)
        0: if (load) begin m_a = a; m_b = b; m_mode = 1; end
        1: begin m_mode = 2; m_t = 0; end
        default: if (load) begin m_a = a; m_b = b; m_mode = 1; end else m_t++;
      endcase
    end
  end

  always @(negedge clk) begin
    logic       e_busy, e_done;
    logic [1:0] e_sel;
    logic [7:0] e_seg;
    int         diff;
    if (armed) begin
      e_busy = (m_mode == 1);
      e_done = (m_mode == 2 && m_t == 0);
      e_sel  = 2'b00;
      e_seg  = 8'h00;
      if (m_mode == 2 && (m_t % CLK_DIV) >= BLANK_CYC) begin
        if (((m_t / CLK_DIV) % 2) == 0) begin
          e_sel = 2'b10;
          e_seg = (m_a < m_b) ? 8'h02 : 8'h00;
        end else begin
          diff  = (m_a > m_b) ? m_a - m_b : m_b - m_a;
          e_sel = 2'b01;
          e_seg = glyph_t[diff];
        end
      end
      e_sel = e_sel ^ SEL_INV;
      e_seg = e_seg ^ SEG_INV;
      vectors += 4;
      if (busy !== e_busy) begin miscompares++; $display("FAIL model_busy t=%0t got %b expected %b", $time, busy, e_busy); end
      if (done !== e_done) begin miscompares++; $display("FAIL model_done t=%0t got %b expected %b", $time, done, e_done); end
      if (tub_sel !== e_sel) begin miscompares++; $display("FAIL model_sel t=%0t got %b expected %b", $time, tub_sel, e_sel); end
      if (tub_control !== e_seg) begin miscompares++; $display("FAIL model_seg t=%0t got %h expected %h", $time, tub_control, e_seg); end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Loads a/b and walks the first three slots: sign, magnitude, sign again.
  task automatic run_pair(input logic [2:0] va, input logic [2:0] vb,
                          input logic [7:0] sign_seg, input logic [7:0] mag_seg);
    a = va; b = vb; load = 1'b1;
    cyc(1);
    load = 1'b0;
    chk("calc_busy", {7'd0, busy}, 8'd1);
    chk("calc_sel", {6'd0, tub_sel}, {6'd0, 2'b00 ^ SEL_INV});
    cyc(1);
    chk("show_done", {7'd0, done}, 8'd1);
    chk("show_blank", {6'd0, tub_sel}, {6'd0, 2'b00 ^ SEL_INV});
    cyc(1);
    chk("sign_sel", {6'd0, tub_sel}, {6'd0, 2'b10 ^ SEL_INV});
    chk("sign_seg", tub_control, sign_seg ^ SEG_INV);
    cyc(4);
    chk("mag_sel", {6'd0, tub_sel}, {6'd0, 2'b01 ^ SEL_INV});
    chk("mag_seg", tub_control, mag_seg ^ SEG_INV);
    cyc(4);
    chk("sign2_sel", {6'd0, tub_sel}, {6'd0, 2'b10 ^ SEL_INV});
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; a = '0; b = '0;
    cyc(2);
    rst = 1'b0;
    cyc(3);
    chk("idle_sel", {6'd0, tub_sel}, {6'd0, 2'b00 ^ SEL_INV});
    chk("idle_seg", tub_control, 8'h00 ^ SEG_INV);
    chk("idle_busy", {7'd0, busy}, 8'd0);

    run_pair(3'd5, 3'd2, 8'h00, 8'hF2);
    run_pair(3'd1, 3'd7, 8'h02, 8'hBE);
    run_pair(3'd3, 3'd3, 8'h00, 8'hFC);
    cyc(4);                              // now mid magnitude slot
    run_pair(3'd0, 3'd7, 8'h02, 8'hE0);

    // load held through CALC: second operand set must not be captured
    a = 3'd5; b = 3'd2; load = 1'b1;
    cyc(1);
    a = 3'd1; b = 3'd7;
    chk("hold_busy", {7'd0, busy}, 8'd1);
    cyc(1);
    load = 1'b0;
    cyc(5);
    chk("hold_mag", tub_control, 8'hF2 ^ SEG_INV);
    a = 3'd0; b = 3'd0;                  // no load: display unchanged
    cyc(8);
    chk("noload_mag", tub_control, 8'hF2 ^ SEG_INV);

    rst = 1'b1;
    cyc(1);
    chk("rst_sel", {6'd0, tub_sel}, {6'd0, 2'b00 ^ SEL_INV});
    chk("rst_seg", tub_control, 8'h00 ^ SEG_INV);
    rst = 1'b0;
    cyc(3);
    chk("post_rst_busy", {7'd0, busy}, 8'd0);

    rst = 1'b1; load = 1'b1; a = 3'd7; b = 3'd0;
    cyc(1);
    rst = 1'b0; load = 1'b0;
    cyc(2);
    chk("rst_wins_busy", {7'd0, busy}, 8'd0);
    chk("rst_wins_sel", {6'd0, tub_sel}, {6'd0, 2'b00 ^ SEL_INV});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
